// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - RSEL_* load-type and WSEL_* store-type encodings
//   - state_t : responder FSM states (IDLE / WAIT / RESP)
//   - size_t  : normalised access size after decoding rsel/wsel
//   - rsel_size / wsel_size : decode (illegal codes fall back to word)
//   - lane_en : byte-lane enables for a given size and byte offset
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [2:0] RSEL_LB  = 3'b000;
  localparam logic [2:0] RSEL_LH  = 3'b001;
  localparam logic [2:0] RSEL_LW  = 3'b010;
  localparam logic [2:0] RSEL_LBU = 3'b100;
  localparam logic [2:0] RSEL_LHU = 3'b101;

  localparam logic [1:0] WSEL_SB = 2'b00;
  localparam logic [1:0] WSEL_SH = 2'b01;
  localparam logic [1:0] WSEL_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unlisted load codes (011, 11x) behave as a full-word load.
  function automatic size_t rsel_size(logic [2:0] rsel);
    case (rsel)
      RSEL_LB, RSEL_LBU: return SZ_BYTE;
      RSEL_LH, RSEL_LHU: return SZ_HALF;
      RSEL_LW:           return SZ_WORD;
      default:           return SZ_WORD;
    endcase
  endfunction

  // Store code 11 behaves as a full-word store.
  function automatic size_t wsel_size(logic [1:0] wsel);
    case (wsel)
      WSEL_SB: return SZ_BYTE;
      WSEL_SH: return SZ_HALF;
      WSEL_SW: return SZ_WORD;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(size_t sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// MEM-stage data-memory request/response bundle.
//   master : pipeline side (drives req_*, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_*)
//
// Handshake: a transfer on a channel happens on a rising clock edge where
// both valid and ready are 1. Once a responder raises rsp_valid it keeps
// rsp_valid, rsp_rdata and rsp_err stable until that transfer. req_ready
// does not depend on req_valid.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_rsel;
  logic [1:0]  req_wsel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_rsel, req_wsel, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_rsel, req_wsel, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for one access.
//   we, addr_lo, rsel, wsel : access being committed
//   wdata      : right-aligned store data
//   rword      : word read from the array
//   be         : byte enables for the array write (0 for loads / errors)
//   wdata_lane : store data replicated into every candidate lane
//   rdata      : shifted and sign/zero-extended load data
//   misalign   : misaligned access flag
// Build option DMEM_MISALIGN_ERR_EN: misaligned half/word accesses are
// flagged and produce no write and zero data. Without it the low address
// bits are forced to the natural alignment of the access size.
// ---------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  rsel,
  input  logic [1:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata,
  output logic        misalign
);

  size_t       sz;
  logic        sign_ld;
  logic [1:0]  off;
  logic [31:0] shifted;
`ifdef DMEM_MISALIGN_ERR_EN
  logic        bad;
`endif

  always_comb begin
    sz      = we ? wsel_size(wsel) : rsel_size(rsel);
    sign_ld = (rsel == RSEL_LB) || (rsel == RSEL_LH);

`ifdef DMEM_MISALIGN_ERR_EN
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = |addr_lo;
    endcase
    off = addr_lo;
`else
    case (sz)
      SZ_BYTE: off = addr_lo;
      SZ_HALF: off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif

    shifted = rword >> {off, 3'b000};
    case (sz)
      SZ_BYTE: rdata = {{24{sign_ld & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{sign_ld & shifted[15]}}, shifted[15:0]};
      default: rdata = rword;
    endcase

    // Replicating the data means the byte enables alone pick the lane.
    case (sz)
      SZ_BYTE: wdata_lane = {4{wdata[7:0]}};
      SZ_HALF: wdata_lane = {2{wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase

    be = we ? lane_en(sz, off) : 4'b0000;

`ifdef DMEM_MISALIGN_ERR_EN
    misalign = bad;
    if (bad) begin
      rdata = 32'd0;
      be    = 4'b0000;
    end
`else
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the MEM-stage data-memory interface. Accepts one
// load/store at a time, waits WAIT_CYCLES wait states, then commits the
// store or registers the extended load data and presents the response.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : dmem_responder_if.slave (request + response channels)
//   dbg_state : current FSM state
// Parameters: DEPTH_WORDS (power of two), WAIT_CYCLES (0..15).
// Build option DMEM_MISALIGN_ERR_EN enables misalignment errors on rsp_err
// (see dmem_lane_align); otherwise rsp_err is always 0.
// The data array is not reset.
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output state_t           dbg_state
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;

  logic        we_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  rsel_q;
  logic [1:0]  wsel_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          commit;
  logic          cur_we;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [2:0]    cur_rsel;
  logic [1:0]    cur_wsel;
  logic [AW-1:0] cur_idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   align_rdata;
  logic          align_misalign;
  logic [31:0]   resp_rdata_d;
  logic          unused_addr_hi;

  // Address bits above the array index are ignored: accesses wrap.
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  assign accept = bus.req_valid && (state == IDLE);

  // With zero wait states the access commits on its acceptance edge, so the
  // live request fields are used while IDLE; otherwise the captured copy.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr[AW+1:0];
      cur_wdata = bus.req_wdata;
      cur_rsel  = bus.req_rsel;
      cur_wsel  = bus.req_wsel;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_rsel  = rsel_q;
      cur_wsel  = wsel_q;
    end
  end

  always_comb begin
    if (WAIT_CYCLES == 0) enter_resp = accept;
    else                  enter_resp = (state == WAIT) && (cnt == WAIT_LAST);
  end

  // Gated by rst so nothing is written while reset is held.
  assign commit       = enter_resp && rst;
  assign cur_idx      = cur_addr[AW+1:2];
  assign rword        = mem[cur_idx];
  assign resp_rdata_d = cur_we ? 32'd0 : align_rdata;

  dmem_lane_align u_align (
    .we         (cur_we),
    .addr_lo    (cur_addr[1:0]),
    .rsel       (cur_rsel),
    .wsel       (cur_wsel),
    .wdata      (cur_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata      (align_rdata),
    .misalign   (align_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rsel_q      <= 3'd0;
      wsel_q      <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[AW+1:0];
            wdata_q <= bus.req_wdata;
            rsel_q  <= bus.req_rsel;
            wsel_q  <= bus.req_wsel;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= resp_rdata_d;
        rsp_err_q   <= align_misalign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cur_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share one set of request drivers: u_dut2 (WAIT_CYCLES=2)
// and u_dut0 (WAIT_CYCLES=0); 'sel' picks which one sees req_valid and
// rsp_ready. A byte-addressed memory model per responder supplies expected
// load data, error flags and latencies.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- shared drivers ----------------
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_rsel;
  logic [1:0]  req_wsel;

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  assign bus2.req_valid = req_valid & ~sel;
  assign bus0.req_valid = req_valid & sel;
  assign bus2.rsp_ready = rsp_ready & ~sel;
  assign bus0.rsp_ready = rsp_ready & sel;
  assign bus2.req_we    = req_we;
  assign bus0.req_we    = req_we;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus0.req_wdata = req_wdata;
  assign bus2.req_rsel  = req_rsel;
  assign bus0.req_rsel  = req_rsel;
  assign bus2.req_wsel  = req_wsel;
  assign bus0.req_wsel  = req_wsel;

  state_t dbg2, dbg0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
  );

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_err;
  logic [31:0] obs_rsp_rdata;
  state_t      obs_state;
  assign obs_req_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign obs_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign obs_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
  assign obs_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
  assign obs_state     = sel ? dbg0 : dbg2;

  // ---------------- checkers ----------------
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-addressed memory; byte address taken modulo 4096 (1024 words).
  logic [7:0] mb [2][4096];

  function automatic int access_size_ld(logic [2:0] rsel);
    if (rsel == 3'b000 || rsel == 3'b100) return 1;
    if (rsel == 3'b001 || rsel == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int access_size_st(logic [1:0] wsel);
    if (wsel == 2'b00) return 1;
    if (wsel == 2'b01) return 2;
    return 4;
  endfunction

  function automatic void model_load(input bit w, input logic [31:0] addr, input logic [2:0] rsel,
                                     output logic [31:0] val, output logic err);
    int size;
    int a;
    bit uns;
    size = access_size_ld(rsel);
    uns  = (rsel == 3'b100) || (rsel == 3'b101);
    a    = int'(addr[11:0]);
    err  = 1'b0;
    val  = 32'd0;
    if (a % size != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      err = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    for (int i = 0; i < size; i++) val = val | (32'(mb[w][a + i]) << (8 * i));
    if (!uns && size < 4 && val[8 * size - 1]) val = val | (32'hFFFF_FFFF << (8 * size));
  endfunction

  function automatic void model_store(input bit w, input logic [31:0] addr, input logic [31:0] data,
                                      input logic [1:0] wsel, output logic err);
    int size;
    int a;
    size = access_size_st(wsel);
    a    = int'(addr[11:0]);
    err  = 1'b0;
    if (a % size != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      err = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    for (int i = 0; i < size; i++) mb[w][a + i] = data[8 * i +: 8];
  endfunction

  // ---------------- driver ----------------
  // One complete transaction on the selected responder, checked against the
  // model: latency (cycles from accept cycle to rsp_valid), data, error,
  // stability while rsp_ready is held low for 'hold' cycles, and return to idle.
  task automatic do_req(input string tag, input bit w, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] rsel, input logic [1:0] wsel,
                        input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          g;
    int          lat;
    if (we) begin
      model_store(w, addr, wdata, wsel, exp_err);
      exp_rd = 32'd0;
    end else begin
      model_load(w, addr, rsel, exp_rd, exp_err);
    end
    exp_lat = w ? 1 : 3;

    sel = w;
    @(negedge clk);
    g = 0;
    while (!obs_req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk1({tag, "_ready_timeout"}, obs_req_ready, 1'b1);

    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_rsel  = rsel;
    req_wsel  = wsel;
    rsp_ready = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (lat == 0) begin
        // Changing the fields after acceptance must not affect the access.
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rsel  = 3'($urandom_range(0, 7));
        req_wsel  = 2'($urandom_range(0, 3));
      end
      lat++;
      if (obs_rsp_valid || lat >= 50) break;
    end
    chk32({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk32({tag, "_rdata"}, obs_rsp_rdata, exp_rd);
    chk1({tag, "_err"}, obs_rsp_err, exp_err);
    rd = obs_rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1({tag, "_hold_valid"}, obs_rsp_valid, 1'b1);
      chk32({tag, "_hold_rdata"}, obs_rsp_rdata, exp_rd);
      chk1({tag, "_hold_err"}, obs_rsp_err, exp_err);
      chk1({tag, "_hold_req_ready"}, obs_req_ready, 1'b0);
      chk32({tag, "_hold_state"}, 32'(obs_state), 32'(RESP));
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1({tag, "_idle_req_ready"}, obs_req_ready, 1'b1);
    chk1({tag, "_idle_rsp_valid"}, obs_rsp_valid, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic        rwe;

    sel       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_rsel  = 3'd0;
    req_wsel  = 2'd0;
    rsp_ready = 1'b0;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_req_ready", obs_req_ready, 1'b1);
    chk1("rst_rsp_valid", obs_rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", obs_rsp_rdata, 32'd0);
    chk1("rst_rsp_err", obs_rsp_err, 1'b0);
    chk32("rst_state", 32'(obs_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Basic store/load and lane extraction.
    do_req("sw_10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, RSEL_LW, WSEL_SW, 0, rd);
    do_req("lw_10", 1'b0, 1'b0, 32'h10, 32'h0, RSEL_LW, WSEL_SW, 0, rd);
    chk32("lw_10_const", rd, 32'hDEAD_BEEF);
    do_req("lb_13", 1'b0, 1'b0, 32'h13, 32'h0, RSEL_LB, WSEL_SW, 0, rd);
    chk32("lb_13_const", rd, 32'hFFFF_FFDE);
    do_req("lbu_13", 1'b0, 1'b0, 32'h13, 32'h0, RSEL_LBU, WSEL_SW, 0, rd);
    chk32("lbu_13_const", rd, 32'h0000_00DE);
    do_req("lh_12", 1'b0, 1'b0, 32'h12, 32'h0, RSEL_LH, WSEL_SW, 0, rd);
    chk32("lh_12_const", rd, 32'hFFFF_DEAD);
    do_req("lhu_12", 1'b0, 1'b0, 32'h12, 32'h0, RSEL_LHU, WSEL_SW, 0, rd);
    chk32("lhu_12_const", rd, 32'h0000_DEAD);

    // Single byte lane write.
    do_req("sb_11", 1'b0, 1'b1, 32'h11, 32'h0000_0055, RSEL_LW, WSEL_SB, 0, rd);
    do_req("lw_10b", 1'b0, 1'b0, 32'h10, 32'h0, RSEL_LW, WSEL_SW, 0, rd);
    chk32("lw_10b_const", rd, 32'hDEAD_55EF);

    // Response held while the requester is not ready.
    do_req("hold4", 1'b0, 1'b0, 32'h10, 32'h0, RSEL_LW, WSEL_SW, 4, rd);

    // Misaligned word load.
    do_req("lw_12", 1'b0, 1'b0, 32'h12, 32'h0, RSEL_LW, WSEL_SW, 0, rd);
`ifdef DMEM_MISALIGN_ERR_EN
    chk32("lw_12_const", rd, 32'h0);
`else
    chk32("lw_12_const", rd, 32'hDEAD_55EF);
`endif

    // Address wrap modulo the array and an illegal rsel code.
    do_req("lw_wrap", 1'b0, 1'b0, 32'hABCD_1010, 32'h0, RSEL_LW, WSEL_SW, 0, rd);
    chk32("lw_wrap_const", rd, 32'hDEAD_55EF);
    do_req("rsel_111", 1'b0, 1'b0, 32'h10, 32'h0, 3'b111, WSEL_SW, 0, rd);

    // Reset during the wait states of a store: the store must not land.
    do_req("sw_20", 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, RSEL_LW, WSEL_SW, 0, rd);
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_wsel  = WSEL_SW;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("abort_in_wait_req_ready", obs_req_ready, 1'b0);
    chk32("abort_in_wait_state", 32'(obs_state), 32'(WAIT));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("abort_rst_req_ready", obs_req_ready, 1'b1);
    chk1("abort_rst_rsp_valid", obs_rsp_valid, 1'b0);
    chk32("abort_rst_rsp_rdata", obs_rsp_rdata, 32'd0);
    chk1("abort_rst_rsp_err", obs_rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("abort_after_rsp_valid", obs_rsp_valid, 1'b0);
    do_req("lw_20", 1'b0, 1'b0, 32'h20, 32'h0, RSEL_LW, WSEL_SW, 0, rd);
    chk32("lw_20_const", rd, 32'hCAFE_F00D);

    // Zero-wait-state responder.
    do_req("z_sw_40", 1'b1, 1'b1, 32'h40, 32'h8765_4321, RSEL_LW, WSEL_SW, 0, rd);
    do_req("z_lw_40", 1'b1, 1'b0, 32'h40, 32'h0, RSEL_LW, WSEL_SW, 0, rd);
    chk32("z_lw_40_const", rd, 32'h8765_4321);
    do_req("z_lh_42", 1'b1, 1'b0, 32'h42, 32'h0, RSEL_LH, WSEL_SW, 2, rd);
    chk32("z_lh_42_const", rd, 32'hFFFF_8765);

    // Random traffic in a pre-initialised window on each responder.
    for (int k = 0; k < 16; k++)
      do_req("init2", 1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom, RSEL_LW, WSEL_SW, 0, rd);
    for (int k = 0; k < 4; k++)
      do_req("init0", 1'b1, 1'b1, 32'h40 + 32'(4 * k), $urandom, RSEL_LW, WSEL_SW, 0, rd);

    for (int k = 0; k < 40; k++) begin
      a   = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
      rwe = 1'($urandom_range(0, 1));
      do_req("rnd2", 1'b0, rwe, a, $urandom, 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), $urandom_range(0, 2), rd);
    end
    for (int k = 0; k < 15; k++) begin
      a   = ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 15)));
      rwe = 1'($urandom_range(0, 1));
      do_req("rnd0", 1'b1, rwe, a, $urandom, 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), $urandom_range(0, 2), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
